// File: rtl/tick_generator_pkg.sv
// Shared definitions for the tick generator: FSM state encoding and tick counter width.
package tick_generator_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StRun       = 2'b01,
        StStepPulse = 2'b10,
        StStepWait  = 2'b11
    } state_e;

    localparam int unsigned TickCountWidth = 8;

endpackage

// File: rtl/tick_generator_if.sv
// Control/status bundle between a tick generator and whatever drives it.
interface tick_generator_if #(
    parameter int unsigned nrOfBits = 16
) ();
    import tick_generator_pkg::*;

    logic                      run;
    logic                      step;
    logic                      load;
    logic [nrOfBits-1:0]       divisor;
    logic                      tick;
    logic [TickCountWidth-1:0] tickCount;
    logic                      busy;

    modport master (
        output run, step, load, divisor,
        input  tick, tickCount, busy
    );

    modport slave (
        input  run, step, load, divisor,
        output tick, tickCount, busy
    );

endinterface

// File: rtl/tick_counter.sv
// Reloadable down-counter with zero flag; saturates at zero instead of wrapping.
module tick_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [Width-1:0] i_value,
    output logic             o_zero
);

    logic [Width-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - Width'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/tick_generator.sv
// Programmable clock-enable tick generator with free-run and single-step modes.
module tick_generator
    import tick_generator_pkg::*;
#(
    parameter int unsigned nrOfBits       = 16,
    parameter int unsigned defaultDivisor = 0
) (
    input logic              i_clock,
    input logic              i_reset,
    tick_generator_if.slave  bus
);

    state_e                    r_state;
    state_e                    w_state_next;
    logic                      r_tick;
    logic                      w_tick_next;
    logic [TickCountWidth-1:0] r_tick_count;
    logic                      r_busy;
    logic [nrOfBits-1:0]       r_divisor;
    logic [nrOfBits-1:0]       w_reload_value;
    logic                      w_cnt_load;
    logic                      w_cnt_dec;
    logic                      w_cnt_clear;
    logic                      w_cnt_zero;

    // A divisor written on the reload cycle takes effect immediately.
    assign w_reload_value = bus.load ? bus.divisor : r_divisor;

    tick_counter #(
        .Width (nrOfBits)
    ) u_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_cnt_clear),
        .i_load  (w_cnt_load),
        .i_dec   (w_cnt_dec),
        .i_value (w_reload_value),
        .o_zero  (w_cnt_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_tick_next  = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_cnt_clear  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.run) begin
                    w_state_next = StRun;
                    w_cnt_load   = 1'b1;
                end else if (bus.step) begin
                    w_state_next = StStepPulse;
                    w_tick_next  = 1'b1;
                end
            end
            StRun: begin
                // Dropping run abandons the current period without a tick.
                if (!bus.run) begin
                    w_state_next = StIdle;
                    w_cnt_clear  = 1'b1;
                end else if (w_cnt_zero) begin
                    w_tick_next = 1'b1;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            StStepPulse: begin
                w_state_next = StStepWait;
            end
            StStepWait: begin
                if (!bus.step) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_tick       <= 1'b0;
            r_tick_count <= '0;
            r_busy       <= 1'b0;
            r_divisor    <= nrOfBits'(defaultDivisor);
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_busy  <= (w_state_next != StIdle);
            if (w_tick_next) begin
                r_tick_count <= r_tick_count + TickCountWidth'(1);
            end
            if (bus.load) begin
                r_divisor <= bus.divisor;
            end
        end
    end

    assign bus.tick      = r_tick;
    assign bus.tickCount = r_tick_count;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_tick_generator.sv
// Directed self-checking bench for tick_generator; cycle n = n-th edge after run/step is driven.
module tb_tick_generator;

    localparam int unsigned NrOfBits       = 16;
    localparam int unsigned DefaultDivisor = 5;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    tick_generator_if #(.nrOfBits(NrOfBits)) bus ();

    tick_generator #(
        .nrOfBits       (NrOfBits),
        .defaultDivisor (DefaultDivisor)
    ) dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.load    = 1'b0;
        bus.divisor = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic load_div(input logic [NrOfBits-1:0] d);
        bus.load    = 1'b1;
        bus.divisor = d;
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_tick got=%0b exp=0", bus.tick);
        end
        checks++;
        if (bus.tickCount !== 8'd0) begin
            failures++;
            $display("FAIL reset_tickCount got=%0d exp=0", bus.tickCount);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%0b exp=0", bus.busy);
        end
    endtask

    task automatic test_run_d2();
        logic       exp;
        logic [7:0] exp_cnt;
        do_reset();
        load_div(16'd2);
        bus.run = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            cycle();
            exp     = (n == 4) || (n == 7) || (n == 10);
            exp_cnt = 8'((n >= 4) + (n >= 7) + (n >= 10));
            checks++;
            if (bus.tick !== exp) begin
                failures++;
                $display("FAIL run_d2_tick cycle=%0d got=%0b exp=%0b", n, bus.tick, exp);
            end
            checks++;
            if (bus.tickCount !== exp_cnt) begin
                failures++;
                $display("FAIL run_d2_count cycle=%0d got=%0d exp=%0d", n, bus.tickCount, exp_cnt);
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL run_d2_busy cycle=%0d got=%0b exp=1", n, bus.busy);
            end
        end
        bus.run = 1'b0;
        cycle();
        checks++;
        if (bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL run_d2_stop got tick=%0b busy=%0b exp tick=0 busy=0", bus.tick, bus.busy);
        end
    endtask

    task automatic test_run_d0();
        logic exp;
        do_reset();
        load_div(16'd0);
        bus.run = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            cycle();
            exp = (n >= 2);
            checks++;
            if (bus.tick !== exp) begin
                failures++;
                $display("FAIL run_d0_tick cycle=%0d got=%0b exp=%0b", n, bus.tick, exp);
            end
        end
        bus.run = 1'b0;
        cycle();
        checks++;
        if (bus.tick !== 1'b0) begin
            failures++;
            $display("FAIL run_d0_after_drop got=%0b exp=0", bus.tick);
        end
        checks++;
        if (bus.tickCount !== 8'd4) begin
            failures++;
            $display("FAIL run_d0_count got=%0d exp=4", bus.tickCount);
        end
    endtask

    task automatic test_step();
        logic exp;
        do_reset();
        bus.step = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            cycle();
            exp = (n == 1);
            checks++;
            if (bus.tick !== exp) begin
                failures++;
                $display("FAIL step_tick cycle=%0d got=%0b exp=%0b", n, bus.tick, exp);
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL step_busy cycle=%0d got=%0b exp=1", n, bus.busy);
            end
        end
        bus.step = 1'b0;
        cycle();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL step_release_busy got=%0b exp=0", bus.busy);
        end
        checks++;
        if (bus.tickCount !== 8'd1) begin
            failures++;
            $display("FAIL step_count got=%0d exp=1", bus.tickCount);
        end
        // run and step together from IDLE must enter RUN (divisor 5: no tick yet)
        bus.run  = 1'b1;
        bus.step = 1'b1;
        cycle();
        checks++;
        if (bus.tick !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL step_run_priority got tick=%0b busy=%0b exp tick=0 busy=1",
                     bus.tick, bus.busy);
        end
        bus.run  = 1'b0;
        bus.step = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_load_mid();
        logic exp;
        do_reset();
        load_div(16'd3);
        bus.run = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            bus.load    = (n == 7);
            bus.divisor = 16'd1;
            cycle();
            exp = (n == 5) || (n == 9) || (n == 11) || (n == 13);
            checks++;
            if (bus.tick !== exp) begin
                failures++;
                $display("FAIL load_mid_tick cycle=%0d got=%0b exp=%0b", n, bus.tick, exp);
            end
        end
        bus.load = 1'b0;
        bus.run  = 1'b0;
        cycle();
    endtask

    task automatic test_load_reload();
        logic exp;
        do_reset();
        load_div(16'd3);
        bus.run = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            bus.load    = (n == 5);
            bus.divisor = 16'd1;
            cycle();
            exp = (n == 5) || (n == 7) || (n == 9);
            checks++;
            if (bus.tick !== exp) begin
                failures++;
                $display("FAIL load_reload_tick cycle=%0d got=%0b exp=%0b", n, bus.tick, exp);
            end
        end
        bus.load = 1'b0;
        bus.run  = 1'b0;
        cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        load_div(16'd0);
        bus.run = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            cycle();
        end
        checks++;
        if (bus.tickCount !== 8'd255) begin
            failures++;
            $display("FAIL wrap_preset got=%0d exp=255", bus.tickCount);
        end
        cycle();
        checks++;
        if (bus.tickCount !== 8'd0 || bus.tick !== 1'b1) begin
            failures++;
            $display("FAIL wrap_zero got count=%0d tick=%0b exp count=0 tick=1",
                     bus.tickCount, bus.tick);
        end
        bus.run = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        logic exp;
        do_reset();
        load_div(16'd0);
        bus.run = 1'b1;
        for (int n = 1; n <= 3; n++) cycle();
        checks++;
        if (bus.tickCount !== 8'd2) begin
            failures++;
            $display("FAIL reset_mid_precount got=%0d exp=2", bus.tickCount);
        end
        bus.run = 1'b0;
        cycle();
        load_div(16'd3);
        bus.run = 1'b1;
        for (int n = 1; n <= 3; n++) cycle();
        // counter is now 1; reset must win over run and load
        reset       = 1'b1;
        bus.load    = 1'b1;
        bus.divisor = 16'd2;
        cycle();
        checks++;
        if (bus.tick !== 1'b0 || bus.tickCount !== 8'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs got tick=%0b count=%0d busy=%0b exp all 0",
                     bus.tick, bus.tickCount, bus.busy);
        end
        reset    = 1'b0;
        bus.load = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            cycle();
            exp = (n == 7);
            checks++;
            if (bus.tick !== exp) begin
                failures++;
                $display("FAIL reset_mid_default_div cycle=%0d got=%0b exp=%0b", n, bus.tick, exp);
            end
        end
        bus.run = 1'b0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_run_d2();
        test_run_d0();
        test_step();
        test_load_mid();
        test_load_reload();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
TICK_GENERATOR -- requirements
Module: tick_generator

Interface
REQ-001 Parameter nrOfBits, default 16: width of divisor and internal down-counter.
REQ-002 Parameter defaultDivisor, default 0: divisor value after reset.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; high = free-running tick generation.
REQ-006 step  input  1  level; rising activity while stopped requests exactly one tick.
REQ-007 load  input  1  high = capture divisor into divisor register this cycle.
REQ-008 divisor  input  nrOfBits  tick period minus one.
REQ-009 tick  output  1  registered one-cycle clock-enable pulse for gated flip-flops.
REQ-010 tickCount  output  8  registered count of ticks issued, wraps.
REQ-011 busy  output  1  registered; high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, RUN, STEP_PULSE, STEP_WAIT; encoding fixed in shared package.
REQ-013 IDLE: run high -> RUN with counter loaded from divisor register; else step high -> STEP_PULSE; else stay; tick low.
REQ-014 RUN: counter==0 -> tick high next cycle, counter reloaded from divisor register; else counter decrements, tick low.
REQ-015 Timing: run first sampled high in cycle 0 -> ticks in cycles D+2, 2D+3, ... (period D+1); D=0 gives tick high every cycle from cycle 2.
REQ-016 RUN with run low -> IDLE next cycle, tick low, counter cleared; no partial tick.
REQ-017 STEP_PULSE: tick high for exactly one cycle, then STEP_WAIT.
REQ-018 STEP_WAIT: remain until step low, then IDLE; holding step high yields only one tick.
REQ-019 run has priority over step in IDLE; step ignored in RUN and STEP_WAIT; run ignored in STEP_PULSE/STEP_WAIT until IDLE.
REQ-020 load high in any state SHALL update divisor register next cycle; new value used only at next reload, never mid-period.
REQ-021 load coincident with reload: the new divisor value SHALL be the one reloaded.
REQ-022 tickCount SHALL increment by 1 in the cycle tick is high; 255 -> 0 wrap, no flag.
REQ-023 Counter arithmetic unsigned nrOfBits; never decremented below 0.

Reset
REQ-024 reset high SHALL, on next rising edge: state IDLE, tick 0, tickCount 0, busy 0, counter 0, divisor register defaultDivisor.
REQ-025 reset has priority over run, step, load in the same cycle; reset mid-RUN or mid-step aborts with no tick issued.
REQ-026 After reset release, run/step sampled normally from the first following cycle.

Structure
REQ-027 Shared package SHALL hold state encoding constants and tickCount width (8).
REQ-028 One sub-module tick_counter SHALL implement the reloadable down-counter with zero flag; FSM and outputs in tick_generator.

Verification
REQ-029 divisor=2, load, then run high continuous -> tick in cycles 4, 7, 10 after run sample; tickCount 1,2,3.
REQ-030 divisor=0, run high 5 cycles then low -> tick high cycles 2-5 consecutive, low after run drop; tickCount=4.
REQ-031 run low, step held high 10 cycles -> exactly one tick, busy high until step low plus one cycle.
REQ-032 running with D=3, load divisor=1 mid-period -> current period completes at 4 cycles, subsequent periods 2 cycles.
REQ-033 tickCount preset to 255 via 255 ticks, one more tick -> tickCount 0.
REQ-034 reset asserted while RUN with counter=1 -> no tick, all outputs 0, divisor register = defaultDivisor next cycle.
